// File: rtl/aq_f_spsram_ctrl_if.sv
// Request/response channel and SRAM macro pins of aq_f_spsram_ctrl.
// slave = controller side, master = requester/SRAM environment side.
interface aq_f_spsram_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
    output req_rdy, rsp_vld, rsp_rdata, init_done,
           sram_a, sram_cen, sram_d, sram_gwen, sram_wen
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
    input  req_rdy, rsp_vld, rsp_rdata, init_done,
           sram_a, sram_cen, sram_d, sram_gwen, sram_wen
  );
endinterface

// File: rtl/aq_f_spsram_ctrl.sv
// Valid/ready front-end for a single-port SRAM with a 2-entry read-response buffer.
// Define AQ_SPSRAM_CTRL_INIT_EN to zero the whole array after every reset.
module aq_f_spsram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  aq_f_spsram_ctrl_if.slave bus
);
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

`ifdef AQ_SPSRAM_CTRL_INIT_EN
  localparam state_e ST_RESET = ST_INIT;
`else
  localparam state_e ST_RESET = ST_RUN;
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_hs;
  logic                  w_sweep;
  logic [2:0]            w_level;

  // Occupancy after this cycle's pop plus the read already in flight must leave room for one more.
  assign w_push         = r_inflight;
  assign w_pop          = (r_occ != 2'd0) & bus.rsp_rdy;
  assign w_level        = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign bus.req_rdy    = r_init_done & (r_state == ST_RUN) & (w_level < 3'd2);
  assign w_hs           = bus.req_vld & bus.req_rdy;
  assign w_sweep        = (r_state == ST_INIT) & cpurst_b;
  assign bus.rsp_vld    = (r_occ != 2'd0);
  assign bus.rsp_rdata  = r_buf[r_rd_ptr];
  assign bus.init_done  = r_init_done;

  // SRAM pin drive: clear sweep, accepted request, or idle.
  always_comb begin
    bus.sram_cen  = 1'b1;
    bus.sram_gwen = 1'b0;
    bus.sram_wen  = {DATA_WIDTH{1'b0}};
    bus.sram_a    = {ADDR_WIDTH{1'b0}};
    bus.sram_d    = {DATA_WIDTH{1'b0}};
    if (w_sweep) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = 1'b1;
      bus.sram_wen  = {DATA_WIDTH{1'b1}};
      bus.sram_a    = r_init_cnt;
      bus.sram_d    = {DATA_WIDTH{1'b0}};
    end else if (w_hs) begin
      bus.sram_cen  = 1'b0;
      bus.sram_gwen = bus.req_wr;
      bus.sram_wen  = bus.req_wr ? bus.req_wmask : {DATA_WIDTH{1'b0}};
      bus.sram_a    = bus.req_addr;
      bus.sram_d    = bus.req_wdata;
    end else begin
      bus.sram_cen  = 1'b1;
    end
  end

  // Control FSM: clear sweep then run; init_done rises with the first RUN cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= ST_RESET;
      r_init_cnt  <= {ADDR_WIDTH{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + ADDR_ONE;
          if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_RESET;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: Q is valid the cycle after the read edge, so capture it one cycle late.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_buf[0]   <= {DATA_WIDTH{1'b0}};
      r_buf[1]   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_inflight <= w_hs & ~bus.req_wr;
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.sram_q;
        r_wr_ptr        <= ~r_wr_ptr;
      end else begin
        r_wr_ptr        <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

// File: tb/tb_aq_f_spsram_ctrl.sv
// Scoreboard bench for aq_f_spsram_ctrl with a behavioural 1024x16 SRAM model.
// Covers both builds of AQ_SPSRAM_CTRL_INIT_EN.
module tb_aq_f_spsram_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            hs;
    bit            lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  exp_t exp_q[$];
  int   rsp_cyc_q[$];
  exp_t mon_e;

  aq_f_spsram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  aq_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: bit-masked write, registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q_r = 16'h0000;
  assign bus.sram_q = q_r;
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (bus.sram_gwen)
        mem[bus.sram_a] <= (mem[bus.sram_a] & ~bus.sram_wen) | (bus.sram_d & bus.sram_wen);
      else
        q_r <= mem[bus.sram_a];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every accepted response is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_b && bus.rsp_vld && bus.rsp_rdy) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("stale_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", {48'd0, bus.rsp_rdata}, {48'd0, mon_e.data});
        if (mon_e.lat) check("rsp_latency", 64'(cyc - mon_e.hs), 64'd2);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m, input logic [DW-1:0] exp_d,
                        input bit push, input bit lat);
    int n = 0;
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    @(negedge clk);
    while (!bus.req_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("req_timeout", 64'(n), 64'd0);
    end else if (!wr && push) begin
      exp_t e;
      e.data = exp_d;
      e.hs   = cyc;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    check("reset_outputs",
          {17'd0, bus.req_rdy, bus.rsp_vld, bus.init_done, bus.sram_cen, bus.sram_gwen,
           bus.sram_wen, bus.sram_a, bus.sram_d},
          {17'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 10'h000, 16'h0000});
  endtask

  task automatic sweep_check();
    int bad = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (bus.sram_cen !== 1'b0 || bus.sram_gwen !== 1'b1 || bus.sram_wen !== 16'hFFFF ||
          bus.sram_d !== 16'h0000 || bus.sram_a !== AW'(k) || bus.init_done !== 1'b0 ||
          bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0)
        bad++;
    end
    check("init_sweep_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    check("init_done_cycle_1024", {61'd0, bus.init_done, bus.req_rdy, bus.sram_cen}, {61'd0, 3'b111});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int bad;
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 10'h000;
    bus.req_wdata = 16'h0000;
    bus.req_wmask = 16'h0000;
    bus.rsp_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst_b = 1'b1;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
    sweep_check();
    do_req(1'b0, 10'h3FF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_drain();
`else
    @(negedge clk);
    @(negedge clk);
    check("init_done_after_release", {62'd0, bus.init_done, bus.req_rdy}, {62'd0, 2'b11});
    @(posedge clk);
    #1;
`endif
    // Full and masked write followed by an immediate read of the same word.
    do_req(1'b1, 10'h005, 16'hA5A5, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    do_req(1'b0, 10'h005, 16'h0000, 16'h0000, 16'hA5A5, 1'b1, 1'b1);
    wait_drain();
    do_req(1'b1, 10'h005, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    do_req(1'b0, 10'h005, 16'h0000, 16'h0000, 16'hA500, 1'b1, 1'b1);
    wait_drain();

    // Back-to-back reads with rsp_rdy held high.
    for (int i = 0; i < 8; i++)
      do_req(1'b1, AW'(i), DW'(16'h1000 + i), 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    rsp_cyc_q.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      do_req(1'b0, AW'(i), 16'h0000, 16'h0000, DW'(16'h1000 + i), 1'b1, 1'b0);
    check("b2b_accept_cycles", 64'(cyc - t0), 64'd8);
    wait_drain();
    bad = 0;
    if (rsp_cyc_q.size() != 8) bad = 99;
    else for (int j = 1; j < 8; j++) if (rsp_cyc_q[j] != rsp_cyc_q[j-1] + 1) bad++;
    check("b2b_rsp_consecutive", 64'(bad), 64'd0);

    // Back-pressure: two reads fill the buffer, a third must be held off.
    bus.rsp_rdy = 1'b0;
    do_req(1'b0, 10'h000, 16'h0000, 16'h0000, 16'h1000, 1'b1, 1'b0);
    do_req(1'b0, 10'h001, 16'h0000, 16'h0000, 16'h1001, 1'b1, 1'b0);
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_addr = 10'h002;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 16'h1000) bad++;
    end
    check("full_hold", 64'(bad), 64'd0);
    bus.req_vld = 1'b0;
    @(posedge clk);
    #1 bus.rsp_rdy = 1'b1;
    @(negedge clk);
    check("rdy_reassert", {63'd0, bus.req_rdy}, 64'd1);
    wait_drain();

`ifdef AQ_SPSRAM_CTRL_INIT_EN
    // Reset in the middle of the clear sweep.
    rst_b = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (300) @(negedge clk);
    @(negedge clk);
    check("sweep_at_300", {53'd0, bus.sram_cen, bus.sram_a}, {53'd0, 1'b0, 10'd300});
    #1 rst_b = 1'b0;
    #1 chk_reset_vals();
    exp_q.delete();
    @(posedge clk);
    #1 rst_b = 1'b1;
    sweep_check();
    @(posedge clk);
    #1;
`endif
    // Reset with one read in flight.
    do_req(1'b1, 10'h00A, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    do_req(1'b0, 10'h00A, 16'h0000, 16'h0000, 16'h1234, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk);
    #1 rst_b = 1'b1;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
    sweep_check();
`endif
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_vld !== 1'b0) bad++;
    end
    check("no_stale_rsp", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
